// File: rtl/mv_vlc_encoder.sv
// MPEG-2 motion-vector VLC encoder: wraps each component delta against its predictor,
// emits motion_code / motion_residual tokens to the bit packer, and returns the updated PMV.
module mv_vlc_encoder (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [31:0] mv_h,
  input  logic signed [31:0] mv_v,
  input  logic signed [31:0] pmv_h,
  input  logic signed [31:0] pmv_v,
  input  logic [3:0]         f_code_h,
  input  logic [3:0]         f_code_v,
  input  logic               mvscale,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [10:0]        out_bits,
  output logic [3:0]         out_len,
  output logic signed [31:0] pmv_out_h,
  output logic signed [31:0] pmv_out_v,
  output logic               done,
  output logic               err,
  output logic [2:0]         dbg_state
);

  // Handshakes: a token moves on a rising edge with out_valid && out_ready; while stalled,
  // out_valid/out_bits/out_len hold. A request is accepted on a rising edge with in_valid && in_ready.
  typedef enum logic [2:0] {IDLE, CALC, H_CODE, H_RES, V_CODE, V_RES, FIN} state_t;

  typedef struct packed {
    logic [10:0] word;
    logic [3:0]  wlen;
    logic [7:0]  res;
    logic [3:0]  r;
    logic        has_res;
  } comp_t;

  state_t             state;
  logic signed [31:0] mv_h_q, mv_v_q, pmv_h_q, pmv_v_q;
  logic [3:0]         fh_q, fv_q;
  logic               scale_q;
  comp_t              h_c, v_c, h_q, v_q;
  logic signed [31:0] pred_v;
  logic               bad_fcode;

  function automatic comp_t encode_comp(input logic signed [31:0] mv,
                                        input logic signed [31:0] pred,
                                        input logic [3:0] fc);
    comp_t              c;
    logic [3:0]         r;
    logic signed [31:0] f, delta, mag;
    logic [31:0]        a;
    logic [4:0]         code;
    logic               s;
    logic [9:0]         base;
    logic [3:0]         blen;
    r     = fc - 4'd1;
    f     = 32'sd1 << r;
    delta = mv - pred;
    if (delta > (f <<< 4) - 32'sd1)
      delta = delta - (f <<< 5);
    else if (delta < -(f <<< 4))
      delta = delta + (f <<< 5);
    s    = delta[31];
    mag  = s ? -delta : delta;
    a    = mag - 32'sd1;
    code = 5'((a >> r) + 32'd1);
    // Base word without the trailing sign bit, and its length.
    case (code)
      5'd1:    {base, blen} = {10'd1,  4'd2};
      5'd2:    {base, blen} = {10'd1,  4'd3};
      5'd3:    {base, blen} = {10'd1,  4'd4};
      5'd4:    {base, blen} = {10'd3,  4'd6};
      5'd5:    {base, blen} = {10'd5,  4'd7};
      5'd6:    {base, blen} = {10'd4,  4'd7};
      5'd7:    {base, blen} = {10'd3,  4'd7};
      5'd8:    {base, blen} = {10'd11, 4'd9};
      5'd9:    {base, blen} = {10'd10, 4'd9};
      5'd10:   {base, blen} = {10'd9,  4'd9};
      5'd11:   {base, blen} = {10'd17, 4'd10};
      5'd12:   {base, blen} = {10'd16, 4'd10};
      5'd13:   {base, blen} = {10'd15, 4'd10};
      5'd14:   {base, blen} = {10'd14, 4'd10};
      5'd15:   {base, blen} = {10'd13, 4'd10};
      5'd16:   {base, blen} = {10'd12, 4'd10};
      default: {base, blen} = {10'd0,  4'd0};
    endcase
    c.r   = r;
    c.res = a[7:0] & ((8'd1 << r) - 8'd1);
    if (delta == 32'sd0) begin
      c.word    = 11'd1;
      c.wlen    = 4'd1;
      c.has_res = 1'b0;
    end else begin
      c.word    = {base, s};
      c.wlen    = blen + 4'd1;
      c.has_res = (r != 4'd0);
    end
    return c;
  endfunction

  assign pred_v    = scale_q ? (pmv_v_q >>> 1) : pmv_v_q;
  assign h_c       = encode_comp(mv_h_q, pmv_h_q, fh_q);
  assign v_c       = encode_comp(mv_v_q, pred_v, fv_q);
  assign bad_fcode = (fh_q == 4'd0) || (fh_q > 4'd9) || (fv_q == 4'd0) || (fv_q > 4'd9);
  assign in_ready  = (state == IDLE) && !rst;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_bits  <= '0;
      out_len   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      pmv_out_h <= '0;
      pmv_out_v <= '0;
      mv_h_q    <= '0;
      mv_v_q    <= '0;
      pmv_h_q   <= '0;
      pmv_v_q   <= '0;
      fh_q      <= '0;
      fv_q      <= '0;
      scale_q   <= 1'b0;
      h_q       <= '0;
      v_q       <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          mv_h_q  <= mv_h;
          mv_v_q  <= mv_v;
          pmv_h_q <= pmv_h;
          pmv_v_q <= pmv_v;
          fh_q    <= f_code_h;
          fv_q    <= f_code_v;
          scale_q <= mvscale;
          state   <= CALC;
        end
        CALC: if (bad_fcode) begin
          done  <= 1'b1;
          err   <= 1'b1;
          state <= FIN;
        end else begin
          h_q       <= h_c;
          v_q       <= v_c;
          out_valid <= 1'b1;
          out_bits  <= h_c.word;
          out_len   <= h_c.wlen;
          state     <= H_CODE;
        end
        H_CODE: if (out_ready) begin
          if (h_q.has_res) begin
            out_bits <= {3'b000, h_q.res};
            out_len  <= h_q.r;
            state    <= H_RES;
          end else begin
            out_bits <= v_q.word;
            out_len  <= v_q.wlen;
            state    <= V_CODE;
          end
        end
        H_RES: if (out_ready) begin
          out_bits <= v_q.word;
          out_len  <= v_q.wlen;
          state    <= V_CODE;
        end
        V_CODE, V_RES: if (out_ready) begin
          if (state == V_CODE && v_q.has_res) begin
            out_bits <= {3'b000, v_q.res};
            out_len  <= v_q.r;
            state    <= V_RES;
          end else begin
            // Last token accepted: publish the new predictors alongside done.
            out_valid <= 1'b0;
            done      <= 1'b1;
            pmv_out_h <= mv_h_q;
            pmv_out_v <= scale_q ? (mv_v_q <<< 1) : mv_v_q;
            state     <= FIN;
          end
        end
        FIN: begin
          done  <= 1'b0;
          err   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mv_vlc_encoder.sv
// Bench for mv_vlc_encoder: directed motion-vector cases plus random vectors, with the
// expected token stream held in a queue and checked as the packer accepts each token.
module tb_mv_vlc_encoder;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [31:0] mv_h = '0, mv_v = '0, pmv_h = '0, pmv_v = '0;
  logic [3:0]         f_code_h = 4'd1, f_code_v = 4'd1;
  logic               mvscale = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [10:0]        out_bits;
  logic [3:0]         out_len;
  logic signed [31:0] pmv_out_h, pmv_out_v;
  logic               done, err;
  logic [2:0]         dbg_state;

  mv_vlc_encoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mv_h(mv_h), .mv_v(mv_v), .pmv_h(pmv_h), .pmv_v(pmv_v),
    .f_code_h(f_code_h), .f_code_v(f_code_v), .mvscale(mvscale),
    .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits), .out_len(out_len),
    .pmv_out_h(pmv_out_h), .pmv_out_v(pmv_out_v), .done(done), .err(err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  logic [14:0] exp_q[$];   // {len, bits}
  int          errors = 0;
  int          checks = 0;
  int          exp_pmv_h = 0, exp_pmv_v = 0;
  bit          rand_ready = 1'b0;
  string       vlc_tab[16] = '{"01", "001", "0001", "000011", "0000101", "0000100", "0000011",
                               "000001011", "000001010", "000001001", "0000010001", "0000010000",
                               "0000001111", "0000001110", "0000001101", "0000001100"};

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(1, 0));
  end

  // Token monitor: hold-stability under stall and in-order token comparison.
  logic        stall_q = 1'b0;
  logic [10:0] bits_q = '0;
  logic [3:0]  len_q = '0;
  always @(negedge clk) begin
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        checks++;
        if (out_valid !== 1'b1 || out_bits !== bits_q || out_len !== len_q) begin
          errors++;
          $display("FAIL hold: valid=%b bits=%b len=%0d, required valid=1 bits=%b len=%0d",
                   out_valid, out_bits, out_len, bits_q, len_q);
        end
      end
      if (out_valid && out_ready) begin
        logic [14:0] tok;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL token_extra: bits=%b len=%0d, required no token", out_bits, out_len);
        end else begin
          tok = exp_q.pop_front();
          if ({out_len, out_bits} !== tok) begin
            errors++;
            $display("FAIL token: bits=%b len=%0d, required bits=%b len=%0d",
                     out_bits, out_len, tok[10:0], tok[14:11]);
          end
        end
      end
      stall_q = out_valid && !out_ready;
      bits_q  = out_bits;
      len_q   = out_len;
    end
  end

  function automatic void push_tok(input int len, input int bits);
    exp_q.push_back({4'(len), 11'(bits)});
  endfunction

  // Reference model for one component; returns number of tokens it queued.
  function automatic int push_comp(input int mv, input int pred, input int fc);
    int r, f, delta, a, code, resid, bits;
    string w;
    r = fc - 1;
    f = 1 << r;
    delta = mv - pred;
    if (delta > 16 * f - 1) delta = delta - 32 * f;
    else if (delta < -16 * f) delta = delta + 32 * f;
    if (delta == 0) begin
      push_tok(1, 1);
      return 1;
    end
    a = ((delta < 0) ? -delta : delta) - 1;
    code = (a >> r) + 1;
    resid = a % f;
    w = vlc_tab[code - 1];
    bits = 0;
    for (int i = 0; i < w.len(); i++) bits = bits * 2 + ((w[i] == "1") ? 1 : 0);
    bits = bits * 2 + ((delta < 0) ? 1 : 0);
    push_tok(w.len() + 1, bits);
    if (r > 0) begin
      push_tok(r, resid);
      return 2;
    end
    return 1;
  endfunction

  function automatic int push_model(input int mh, input int mv, input int ph, input int pv,
                                    input int fh, input int fv, input bit sc);
    int n;
    n = push_comp(mh, ph, fh);
    n = n + push_comp(mv, sc ? (pv >>> 1) : pv, fv);
    exp_pmv_h = mh;
    exp_pmv_v = sc ? (mv * 2) : mv;
    return n;
  endfunction

  task automatic issue(input int a_mh, input int a_mv, input int a_ph, input int a_pv,
                       input logic [3:0] a_fh, input logic [3:0] a_fv, input logic a_sc);
    int k;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL in_ready_wait: in_ready=%b, required 1", in_ready);
    end
    mv_h = a_mh; mv_v = a_mv; pmv_h = a_ph; pmv_v = a_pv;
    f_code_h = a_fh; f_code_v = a_fv; mvscale = a_sc;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // exp_lat counts cycles from the accept edge to the done cycle; 0 skips that check.
  task automatic wait_done(input int exp_lat, input logic exp_err);
    int k;
    bit seen;
    k = 0;
    seen = 1'b0;
    while (k < 300 && !seen) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL busy_ready: in_ready=%b, required 0", in_ready);
        end
      end
      if (done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles, required done", k);
    end else begin
      if (exp_lat > 0) begin
        checks++;
        if (k != exp_lat) begin
          errors++;
          $display("FAIL done_latency: %0d cycles, required %0d", k, exp_lat);
        end
      end
      checks++;
      if (err !== exp_err) begin
        errors++;
        $display("FAIL err_flag: err=%b, required %b", err, exp_err);
      end
      checks++;
      if (pmv_out_h !== exp_pmv_h || pmv_out_v !== exp_pmv_v) begin
        errors++;
        $display("FAIL pmv_out: h=%0d v=%0d, required h=%0d v=%0d",
                 pmv_out_h, pmv_out_v, exp_pmv_h, exp_pmv_v);
      end
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL tokens_left: %0d outstanding, required 0", exp_q.size());
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || err !== 1'b0) begin
        errors++;
        $display("FAIL done_pulse: done=%b err=%b one cycle later, required 0 0", done, err);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
        out_bits !== 11'd0 || out_len !== 4'd0 || pmv_out_h !== 0 || pmv_out_v !== 0) begin
      errors++;
      $display("FAIL reset_values: ready=%b valid=%b done=%b err=%b bits=%b len=%0d pmv=%0d/%0d, required all 0",
               in_ready, out_valid, done, err, out_bits, out_len, pmv_out_h, pmv_out_v);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b state=%0d, required 1 and 0", in_ready, dbg_state);
    end
  endtask

  task automatic test_zero_vector();
    push_tok(1, 1);
    push_tok(1, 1);
    exp_pmv_h = 0;
    exp_pmv_v = 0;
    issue(0, 0, 0, 0, 4'd1, 4'd1, 1'b0);
    wait_done(4, 1'b0);
  endtask

  task automatic test_sign();
    push_tok(5, 11'b00010);
    push_tok(1, 1);
    exp_pmv_h = 3;
    exp_pmv_v = 0;
    issue(3, 0, 0, 0, 4'd1, 4'd1, 1'b0);
    wait_done(4, 1'b0);
    push_tok(5, 11'b00011);
    push_tok(1, 1);
    exp_pmv_h = -3;
    issue(-3, 0, 0, 0, 4'd1, 4'd1, 1'b0);
    wait_done(4, 1'b0);
  endtask

  task automatic test_residual();
    push_tok(5, 11'b00010);
    push_tok(1, 0);
    push_tok(1, 1);
    exp_pmv_h = 5;
    exp_pmv_v = 0;
    issue(5, 0, 0, 0, 4'd2, 4'd1, 1'b0);
    wait_done(5, 1'b0);
  endtask

  task automatic test_wrap();
    push_tok(11, 11'b00000100000);
    push_tok(1, 1);
    exp_pmv_h = -10;
    exp_pmv_v = 0;
    issue(-10, 0, 10, 0, 4'd1, 4'd1, 1'b0);
    wait_done(4, 1'b0);
  endtask

  task automatic test_field_scaling();
    push_tok(1, 1);
    push_tok(4, 11'b0010);
    exp_pmv_h = 0;
    exp_pmv_v = 12;
    issue(0, 6, 0, 8, 4'd1, 4'd1, 1'b1);
    wait_done(4, 1'b0);
  endtask

  task automatic test_backpressure();
    void'(push_model(-13, 7, 0, 0, 3, 2, 1'b0));
    out_ready = 1'b0;
    issue(-13, 7, 0, 0, 4'd3, 4'd2, 1'b0);
    repeat (4) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_done(0, 1'b0);
  endtask

  task automatic test_error();
    issue(4, 4, 0, 0, 4'd0, 4'd1, 1'b0);
    wait_done(2, 1'b1);
    issue(4, 4, 0, 0, 4'd2, 4'd10, 1'b0);
    wait_done(2, 1'b1);
  endtask

  task automatic test_reset_abort();
    bit seen;
    void'(push_model(3, 2, 0, 0, 1, 1, 1'b0));
    issue(3, 2, 0, 0, 4'd1, 4'd1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || exp_q.size() != 1) begin
      errors++;
      $display("FAIL abort_pending: valid=%b queued=%0d, required 1 and 1", out_valid, exp_q.size());
    end
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen || in_ready !== 1'b1 || pmv_out_h !== 0 || pmv_out_v !== 0) begin
      errors++;
      $display("FAIL abort: done_seen=%b in_ready=%b pmv=%0d/%0d, required 0 1 0/0",
               seen, in_ready, pmv_out_h, pmv_out_v);
    end
    exp_q.delete();
    exp_pmv_h = 0;
    exp_pmv_v = 0;
  endtask

  task automatic test_back_to_back();
    int n;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n = push_model(i * 5 - 4, 9 - i * 7, i, -i, i + 2, 3 - i, 1'(i & 1));
      issue(i * 5 - 4, 9 - i * 7, i, -i, 4'(i + 2), 4'(3 - i), 1'(i & 1));
      wait_done(2 + n, 1'b0);
    end
  endtask

  task automatic test_random();
    int fh, fv, mh, mv, ph, pv;
    bit sc;
    rand_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      fh = int'($urandom_range(9, 1));
      fv = int'($urandom_range(9, 1));
      mh = int'($urandom_range(32 * (1 << (fh - 1)) - 1, 0)) - 16 * (1 << (fh - 1));
      ph = int'($urandom_range(32 * (1 << (fh - 1)) - 1, 0)) - 16 * (1 << (fh - 1));
      mv = int'($urandom_range(32 * (1 << (fv - 1)) - 1, 0)) - 16 * (1 << (fv - 1));
      pv = int'($urandom_range(32 * (1 << (fv - 1)) - 1, 0)) - 16 * (1 << (fv - 1));
      sc = 1'($urandom_range(1, 0));
      void'(push_model(mh, mv, ph, pv, fh, fv, sc));
      issue(mh, mv, ph, pv, 4'(fh), 4'(fv), sc);
      wait_done(0, 1'b0);
    end
    rand_ready = 1'b0;
    #2 out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_zero_vector();
    test_sign();
    test_residual();
    test_wrap();
    test_field_scaling();
    test_backpressure();
    test_error();
    test_reset_abort();
    test_back_to_back();
    test_random();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mv_vlc_encoder.md
# mv_vlc_encoder

Encoder-side counterpart to the motion-vector decode path. It takes one macroblock motion vector (horizontal and vertical) and its predictor (PMV), plus the per-component f_code. For each component it computes the MPEG-2 wrapped delta, motion_code and motion_residual, then emits the variable-length code words as tokens on a valid/ready stream to the downstream bit packer (putbits). It also returns the updated PMV so the picture-level encoder can carry prediction state forward.

## Interface
- No parameters; widths are fixed by the MPEG-2 tables.
- clk  in  1  single clock, rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  vector request valid
- in_ready  out  1  high only in IDLE while rst is low
- mv_h, mv_v  in  32  signed target vector components (half-pel units)
- pmv_h, pmv_v  in  32  signed predictors
- f_code_h, f_code_v  in  4  legal range 1..9
- mvscale  in  1  field-in-frame vertical scaling
- out_valid  out  1  token valid
- out_ready  in  1  packer accepts token
- out_bits  out  11  code word, right-aligned, MSB sent first
- out_len  out  4  number of valid bits, 1..11
- pmv_out_h, pmv_out_v  out  32  updated predictors; valid from done, held until the next accept
- done  out  1  one-cycle pulse, request complete
- err  out  1  one-cycle pulse with done when an f_code is illegal

## Operation
- **FSM states:** IDLE, CALC, H_CODE, H_RES, V_CODE, V_RES, FIN.
- **IDLE:** on in_valid && in_ready, latch all inputs and go to CALC.
- **CALC, per component c:**
  - r = f_code_c - 1, f = 1<<r, high = 16f-1, low = -16f, range = 32f.
  - pred = pmv_c, except for the vertical component when mvscale=1: pred = pmv_v >>> 1 (arithmetic shift).
  - delta = mv_c - pred. If delta > high, subtract range; if delta < low, add range.
  - If delta = 0: code = 0, no residual.
  - Otherwise: a = |delta| - 1, code = (a>>r)+1, residual = a & (f-1), sign bit s = (delta<0).
  - If either f_code is 0 or >9, go to FIN with err set and emit no tokens.
- **Motion-code VLC table.** The listed word has s appended as the last bit; code 0 is "1" with no sign bit.
  - 1 → 01s
  - 2 → 001s
  - 3 → 0001s
  - 4 → 000011s
  - 5 → 0000101s
  - 6 → 0000100s
  - 7 → 0000011s
  - 8 → 000001011s
  - 9 → 000001010s
  - 10 → 000001001s
  - 11 → 0000010001s
  - 12 → 0000010000s
  - 13 → 0000001111s
  - 14 → 0000001110s
  - 15 → 0000001101s
  - 16 → 0000001100s
- **Emit sequence:** H_CODE, then H_RES, then V_CODE, then V_RES.
  - A RES state is skipped when r = 0 or code = 0.
  - The residual token is r bits long (out_len = r).
- **FIN:**
  - done = 1. pmv_out_h = mv_h.
  - pmv_out_v = mv_v << 1 if mvscale, else mv_v.
  - On err, the pmv outputs are left unchanged.
  - Return to IDLE.
- mv values outside [low, high] are the caller's responsibility; the block encodes the wrapped delta regardless.

## Timing
- **Reset values:** state IDLE; out_valid, done and err are 0; out_bits, out_len and pmv_out_* are 0. in_ready = 0 while rst is high.
- **Latency:** accept at edge N → CALC in cycle N+1 → first out_valid in cycle N+2.
- With out_ready held high, each token takes one cycle.
- done rises in the cycle after the last token handshake (or in cycle N+2 on err).
- **Minimum request time:** 4 cycles from accept to done (two 1-token components).
- **Handshake:**
  - A token transfers on a rising edge with out_valid && out_ready.
  - While out_ready is low, out_valid, out_bits and out_len hold stable.
  - out_valid never drops without a transfer.
- in_ready is low from the accept edge until the FSM returns to IDLE. in_valid asserted outside IDLE is ignored.
- rst asserted mid-request aborts immediately: no done pulse, pmv outputs cleared, IDLE on the next cycle.

## Test plan
- **Zero vector:** f_code 1/1, pmv 0/0, mv 0/0, out_ready=1 → tokens (1, len1), (1, len1); done at accept+4; pmv_out 0/0.
- **Sign handling:** f_code_h=1, pmv_h=0, mv_h=3 → H token 00010 len5. Repeat with mv_h=-3 → 00011 len5.
- **Residual:** f_code_h=2, pmv_h=0, mv_h=5 → code 3 and residual 0, giving tokens 00010 len5 then 0 len1. f_code_v=1 gives no V residual.
- **Wrap:** f_code_h=1, pmv_h=10, mv_h=-10 → delta -20 wraps to 12 → 00000100000 len11; pmv_out_h = -10.
- **Field scaling:** mvscale=1, f_code_v=1, pmv_v=8, mv_v=6 → pred 4, delta 2 → 0010 len4; pmv_out_v=12.
- **Backpressure and errors:**
  - Drop out_ready for 3 cycles during H_CODE → outputs stable, no token lost or duplicated.
  - f_code_h=0 → err and done pulse together at accept+2, no tokens, pmv outputs unchanged.
  - rst pulsed during V_CODE → no done, in_ready=1 after rst falls.
